// File: rtl/frame_controller_pkg.sv
// Shared types and default constants for the frame controller and its
// coordinate counter.
package frame_controller_pkg;

    localparam int unsigned DEF_IMG_W    = 100;
    localparam int unsigned DEF_IMG_H    = 100;
    localparam int unsigned DEF_PIPE_LAT = 2;

    localparam logic [7:0] BLACK_PIXEL = 8'h00;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RX,
        SHIFT,
        WAIT_PIPE,
        SEND,
        WAIT_TX,
        DONE
    } state_t;

endpackage

// File: rtl/frame_controller_coord.sv
// Row/column pixel counter with end-of-line wrap and last-pixel flag.
module frame_coord_counter
    import frame_controller_pkg::*;
#(
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H,
    parameter int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1,
    parameter int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last
);

    logic col_end;

    assign col_end = (col == COL_W'(IMG_W - 1));
    assign last    = col_end && (row == ROW_W'(IMG_H - 1));

    // Wrapping both coordinates at the final pixel keeps row inside 0..IMG_H-1.
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_end) begin
                col <= '0;
                row <= last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/frame_controller.sv
// Per-pixel sequencer: UART byte in -> window datapath -> bordered byte out
// to the UART transmitter, one pixel at a time over a whole frame.
module frame_controller
    import frame_controller_pkg::*;
#(
    parameter int unsigned IMG_W    = DEF_IMG_W,
    parameter int unsigned IMG_H    = DEF_IMG_H,
    parameter int unsigned PIPE_LAT = DEF_PIPE_LAT
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       win_shift,
    output logic [7:0] win_data,
    input  logic [7:0] win_pixel,
    input  logic       tx_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);

    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned CNT_W = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;

    state_t           state, next_state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             last;
    logic [CNT_W-1:0] lat_cnt;
    logic             guard;
    logic             interior;

    logic accept_start, accept_rx, pipe_done, do_send, advance;

    frame_coord_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_coord (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (accept_start),
        .advance (advance),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    assign busy     = (state != IDLE);
    assign interior = (32'(row) >= 32'd2) && (32'(col) >= 32'd2);

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state   = state;
        accept_start = 1'b0;
        accept_rx    = 1'b0;
        pipe_done    = 1'b0;
        do_send      = 1'b0;
        advance      = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept_start = 1'b1;
                next_state   = WAIT_RX;
            end
            WAIT_RX: if (rx_valid) begin
                accept_rx  = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: next_state = WAIT_PIPE;
            WAIT_PIPE: if (lat_cnt == '0) begin
                pipe_done  = 1'b1;
                next_state = SEND;
            end
            SEND: if (tx_ready) begin
                do_send    = 1'b1;
                next_state = WAIT_TX;
            end
            // guard masks tx_ready in the cycle tx_start is still high
            WAIT_TX: if (!guard && tx_ready) begin
                advance    = 1'b1;
                next_state = last ? DONE : WAIT_RX;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            win_shift  <= 1'b0;
            win_data   <= BLACK_PIXEL;
            tx_start   <= 1'b0;
            tx_data    <= BLACK_PIXEL;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
            guard      <= 1'b0;
            lat_cnt    <= '0;
        end else begin
            win_shift  <= (state == SHIFT);
            tx_start   <= do_send;
            frame_done <= (state == DONE);
            guard      <= do_send;

            if (accept_rx) win_data <= rx_data;

            if (state == SHIFT)
                lat_cnt <= CNT_W'(PIPE_LAT);
            else if (state == WAIT_PIPE && lat_cnt != '0)
                lat_cnt <= lat_cnt - 1'b1;

            if (pipe_done) tx_data <= interior ? win_pixel : BLACK_PIXEL;

            if (accept_start)
                overrun <= 1'b0;
            else if (rx_valid && state != IDLE && state != WAIT_RX)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_frame_controller.sv
// Directed bench for frame_controller on a 4x4 frame with PIPE_LAT=2.
module tb_frame_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic [7:0] win_pixel = 8'h00;
    logic       tx_ready = 1'b1;
    logic       win_shift, tx_start, busy, frame_done, overrun;
    logic [7:0] win_data, tx_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] tx_q[$];
    int fd_cnt = 0;
    int fd_at  = -1;

    always #5 clk = ~clk;

    frame_controller #(
        .IMG_W    (4),
        .IMG_H    (4),
        .PIPE_LAT (2)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .win_shift  (win_shift),
        .win_data   (win_data),
        .win_pixel  (win_pixel),
        .tx_ready   (tx_ready),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always @(negedge clk) begin
        if (tx_start) tx_q.push_back(tx_data);
        if (frame_done) begin
            fd_cnt++;
            fd_at = tx_q.size();
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_pixel(input logic [7:0] d, input bit inject);
        int waited = 0;
        bit seen   = 1'b0;
        rx_data  = d;
        rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
        while (!seen && waited < 40) begin
            tick;
            waited++;
            if (tx_start) seen = 1'b1;
        end
        check($sformatf("tx_start_seen_%0h", d), 32'(seen), 32'd1);
        if (inject) begin
            rx_data  = 8'hEE;
            rx_valid = 1'b1;
            tick;
            rx_valid = 1'b0;
            repeat (2) tick;
        end else begin
            repeat (3) tick;
        end
    endtask

    task automatic check_frame(input string tag, input logic [7:0] pix);
        logic [7:0] exp;
        check({tag, "_count"}, 32'(tx_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < tx_q.size(); i++) begin
            exp = ((i / 4) >= 2 && (i % 4) >= 2) ? pix : 8'h00;
            check($sformatf("%s_byte%0d", tag, i), 32'(tx_q[i]), 32'(exp));
        end
        tx_q.delete();
    endtask

    initial begin
        int lat;
        int cnt;

        // Reset and idle
        reset_n = 1'b0;
        repeat (3) tick;
        reset_n = 1'b1;
        repeat (10) tick;
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_tx_start",   32'(tx_start),   32'd0);
        check("rst_win_shift",  32'(win_shift),  32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_overrun",    32'(overrun),    32'd0);
        check("rst_tx_data",    32'(tx_data),    32'h00);
        check("rst_win_data",   32'(win_data),   32'h00);

        // Frame 1: first-pixel latency, then border pattern
        win_pixel = 8'hAA;
        start = 1'b1;
        tick;
        start = 1'b0;
        check("f1_busy", 32'(busy), 32'd1);
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
        lat = 1;
        while (!win_shift && lat < 20) begin
            tick;
            lat++;
        end
        check("lat_rx_to_shift", 32'(lat), 32'd2);
        check("lat_win_data", 32'(win_data), 32'h55);
        lat = 0;
        while (!tx_start && lat < 20) begin
            tick;
            lat++;
        end
        check("lat_shift_to_tx", 32'(lat), 32'd4);
        check("lat_tx_data", 32'(tx_data), 32'h00);
        repeat (3) tick;
        for (int i = 1; i < 16; i++) send_pixel(8'(i), 1'b0);
        repeat (5) tick;
        check_frame("border", 8'hAA);
        check("f1_done_cnt", 32'(fd_cnt), 32'd1);
        check("f1_done_at",  32'(fd_at),  32'd16);
        check("f1_idle",     32'(busy),   32'd0);
        check("f1_overrun",  32'(overrun), 32'd0);

        // Frame 2: backpressure on pixel 0, overrun injected on pixel 5
        start = 1'b1;
        tick;
        start = 1'b0;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
        repeat (4) tick;
        cnt = 0;
        repeat (50) begin
            tick;
            if (tx_start) cnt++;
        end
        check("bp_hold", 32'(cnt), 32'd0);
        tx_ready = 1'b1;
        tick;
        check("bp_release", 32'(tx_start), 32'd1);
        cnt = 1;
        repeat (5) begin
            tick;
            if (tx_start) cnt++;
        end
        check("bp_single_pulse", 32'(cnt), 32'd1);
        for (int i = 1; i < 16; i++) begin
            send_pixel(8'(i), i == 5);
            if (i == 5) check("overrun_set", 32'(overrun), 32'd1);
        end
        repeat (5) tick;
        check_frame("bp", 8'hAA);
        check("f2_done_cnt",     32'(fd_cnt),  32'd2);
        check("overrun_sticky",  32'(overrun), 32'd1);

        // Frame 3: start clears overrun; reset during pixel 7 aborts
        start = 1'b1;
        tick;
        start = 1'b0;
        check("overrun_cleared", 32'(overrun), 32'd0);
        for (int i = 0; i < 7; i++) send_pixel(8'(i), 1'b0);
        rx_data  = 8'h07;
        rx_valid = 1'b1;
        tick;
        rx_valid = 1'b0;
        repeat (2) tick;
        reset_n = 1'b0;
        repeat (2) tick;
        reset_n = 1'b1;
        check("abort_busy", 32'(busy), 32'd0);
        repeat (20) tick;
        check("abort_tx_count", 32'(tx_q.size()), 32'd7);
        check("abort_no_done",  32'(fd_cnt),      32'd2);
        check("abort_idle",     32'(busy),        32'd0);
        tx_q.delete();

        // Frame 4: start with a coincident rx byte, then a full frame
        win_pixel = 8'h3C;
        start    = 1'b1;
        rx_data  = 8'h99;
        rx_valid = 1'b1;
        tick;
        start    = 1'b0;
        rx_valid = 1'b0;
        check("start_rx_overrun", 32'(overrun), 32'd0);
        check("start_rx_busy",    32'(busy),    32'd1);
        for (int i = 0; i < 16; i++) send_pixel(8'(i + 16), 1'b0);
        repeat (5) tick;
        check_frame("after_reset", 8'h3C);
        check("f4_done_cnt", 32'(fd_cnt), 32'd3);
        check("f4_done_at",  32'(fd_at),  32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_controller.md
FRAME_CONTROLLER -- requirements
Module: frame_controller

Interface
REQ-001 SHALL have parameter IMG_W, default 100: image width in pixels.
REQ-002 SHALL have parameter IMG_H, default 100: image height in pixels.
REQ-003 SHALL have parameter PIPE_LAT, default 2: cycles from win_shift to a valid win_pixel.
REQ-004 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-005 SHALL have port reset_n, input, 1: synchronous, active-low reset.
REQ-006 SHALL have port start, input, 1: begin a frame; sampled only in IDLE.
REQ-007 SHALL have ports rx_valid, input, 1, and rx_data, input, 8: one-cycle pixel strobe and byte from the UART receiver.
REQ-008 SHALL have ports win_shift, output, 1, and win_data, output, 8: one-cycle push of a pixel into the window datapath.
REQ-009 SHALL have port win_pixel, input, 8: window datapath result.
REQ-010 SHALL have ports tx_ready, input, 1, tx_start, output, 1, and tx_data, output, 8: UART transmitter handshake.
REQ-011 SHALL have ports busy, output, 1 (state not IDLE), frame_done, output, 1 (one-cycle pulse), and overrun, output, 1 (sticky error).

Function
REQ-012 SHALL implement the states IDLE, WAIT_RX, SHIFT, WAIT_PIPE, SEND, WAIT_TX and DONE.
REQ-013 IDLE: on start=1, clear row, col and overrun, then go to WAIT_RX.
REQ-014 WAIT_RX: on rx_valid=1, register rx_data into win_data, then go to SHIFT.
REQ-015 SHIFT: assert win_shift for exactly one cycle, load the latency counter with PIPE_LAT, then go to WAIT_PIPE.
REQ-016 WAIT_PIPE: decrement the counter; when it reaches 0, capture tx_data and go to SEND.
REQ-017 tx_data SHALL be win_pixel when row>=2 and col>=2; otherwise it SHALL be 8'h00 (black border).
REQ-018 SEND: hold until tx_ready=1, then assert tx_start for one cycle and go to WAIT_TX.
REQ-019 WAIT_TX: ignore tx_ready on the first cycle (guard), then leave when tx_ready=1.
REQ-020 On leaving WAIT_TX, the coordinates SHALL advance: col+1; at col=IMG_W-1, col wraps to 0 and row increments.
REQ-021 After pixel (IMG_H-1, IMG_W-1), the next state SHALL be DONE; otherwise it SHALL be WAIT_RX.
REQ-022 DONE: assert frame_done for one cycle, then go to IDLE.
REQ-023 Exactly IMG_W*IMG_H tx_start pulses SHALL occur per frame, one per received pixel, in receive order.
REQ-024 rx_valid=1 while busy and not in WAIT_RX SHALL set overrun; the byte is dropped and no state change occurs.
REQ-025 overrun SHALL hold until the next accepted start or reset.
REQ-026 start while busy SHALL be ignored.
REQ-027 Simultaneous rx_valid and start in IDLE: start is taken and the byte is dropped without setting overrun.
REQ-028 row and col SHALL be $clog2 of IMG_H and IMG_W bits wide and SHALL never exceed IMG_H-1 and IMG_W-1.

Reset
REQ-029 While reset_n=0 at a clock edge, the block SHALL enter IDLE; row, col and the latency counter SHALL be 0; win_shift, tx_start, busy, frame_done and overrun SHALL be 0; win_data and tx_data SHALL be 8'h00.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no frame_done and no further tx_start pulses.

Structure
REQ-031 A shared package SHALL hold the state enumeration, the default IMG_W/IMG_H/PIPE_LAT constants and BLACK_PIXEL=8'h00.
REQ-032 The row/column counter with wrap and last-pixel flag SHALL be one sub-module, frame_coord_counter; everything else stays in frame_controller.

Verification
REQ-033 Reset idle: hold reset_n=0 for 3 cycles, release, idle 10 cycles -> busy=0, tx_start=0, win_shift=0, frame_done=0.
REQ-034 Latency: with IMG_W=IMG_H=4, send 8'h55 while tx_ready=1 -> win_shift 2 cycles after rx_valid; tx_start with tx_data=8'h00 follows PIPE_LAT+2 cycles after win_shift.
REQ-035 Border: 4x4 frame, win_pixel=8'hAA constant -> 16 tx bytes; bytes at indices 10, 11, 14 and 15 are 8'hAA; all others are 8'h00; frame_done once after the 16th byte.
REQ-036 Backpressure: hold tx_ready=0 for 50 cycles in SEND -> no tx_start; with tx_ready=1 on the following cycle, tx_start pulses once.
REQ-037 Overrun: rx_valid pulsed during WAIT_TX -> overrun=1 and byte dropped; start after DONE clears overrun.
REQ-038 Mid-frame reset: reset_n=0 at pixel 7 of a 4x4 frame -> IDLE, no frame_done; a new 4x4 frame then completes normally with 16 outputs.
